// File: rtl/opl3_pkg.sv
// Shared constants for the OPL3 interval-timer controller: register map, tick intervals, status layout.
package opl3_pkg;

  localparam int unsigned REG_TIMER_WIDTH = 8;
  localparam int unsigned ADDR_WIDTH      = 9;

  localparam logic [7:0] REG_TIMER1     = 8'h02;
  localparam logic [7:0] REG_TIMER2     = 8'h03;
  localparam logic [7:0] REG_TIMER_CTRL = 8'h04;

  localparam int unsigned CLK_FREQ_HZ        = 50_000_000;
  localparam int unsigned T1_TICK_CYCLES_DEF = (CLK_FREQ_HZ / 1_000_000) * 80;
  localparam int unsigned T2_TICK_CYCLES_DEF = (CLK_FREQ_HZ / 1_000_000) * 320;

  // Timer control register (0x04) bit positions
  localparam int unsigned CTRL_RST_BIT = 7;
  localparam int unsigned CTRL_MT1_BIT = 6;
  localparam int unsigned CTRL_MT2_BIT = 5;
  localparam int unsigned CTRL_ST2_BIT = 1;
  localparam int unsigned CTRL_ST1_BIT = 0;

  typedef struct packed {
    logic       irq;
    logic       ft1;
    logic       ft2;
    logic [4:0] rsvd;
  } status_t;

  function automatic logic is_bank0_reg(input logic [ADDR_WIDTH-1:0] addr,
                                        input logic [7:0]            reg_addr);
    return !addr[ADDR_WIDTH-1] && (addr[7:0] == reg_addr);
  endfunction

endpackage

// File: rtl/opl3_timer_chan.sv
// One OPL3 interval timer: tick prescaler, 8-bit up-counter with reload, one-cycle overflow pulse.
module opl3_timer_chan
  import opl3_pkg::*;
#(
  parameter int unsigned TICK_CYCLES = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [REG_TIMER_WIDTH-1:0] reload,
  output logic                       ovf
);

  localparam int unsigned PRE_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_CYCLES - 1);

  logic                       start_q, start_d;
  logic [PRE_W-1:0]           pre_q, pre_d;
  logic [REG_TIMER_WIDTH-1:0] cnt_q, cnt_d;
  logic                       ovf_q, ovf_d;

  // start is the next-state run bit, so a 0->1 load lands on the same edge the run bit rises
  always_comb begin
    start_d = start;
    pre_d   = pre_q;
    cnt_d   = cnt_q;
    ovf_d   = 1'b0;
    if (start && !start_q) begin
      cnt_d = reload;
      pre_d = '0;
    end else if (start) begin
      if (pre_q == PRE_LAST) begin
        pre_d = '0;
        if (cnt_q == '1) begin
          cnt_d = reload;
          ovf_d = 1'b1;
        end else begin
          cnt_d = cnt_q + REG_TIMER_WIDTH'(1);
        end
      end else begin
        pre_d = pre_q + PRE_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      start_q <= 1'b0;
      pre_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      start_q <= start_d;
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ovf = ovf_q;

endmodule

// File: rtl/opl3_timer_ctrl.sv
// OPL3 timer register block: decodes bank-0 regs 0x02-0x04, runs T1/T2, latches overflow flags and IRQ.
module opl3_timer_ctrl
  import opl3_pkg::*;
#(
  parameter int unsigned T1_TICK_CYCLES = T1_TICK_CYCLES_DEF,
  parameter int unsigned T2_TICK_CYCLES = T2_TICK_CYCLES_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [7:0]            wr_data,
  output logic [7:0]            status,
  output logic                  irq,
  output logic                  t1_running,
  output logic                  t2_running
);

  logic [REG_TIMER_WIDTH-1:0] t1_reload_q, t1_reload_d;
  logic [REG_TIMER_WIDTH-1:0] t2_reload_q, t2_reload_d;
  logic mt1_q, mt1_d, mt2_q, mt2_d;
  logic st1_q, st1_d, st2_q, st2_d;
  logic ft1_q, ft1_d, ft2_q, ft2_d;
  logic irq_q, irq_d;
  logic t1_wr, t2_wr, ctrl_wr;
  logic ovf1, ovf2;

  assign t1_wr   = wr && is_bank0_reg(wr_addr, REG_TIMER1);
  assign t2_wr   = wr && is_bank0_reg(wr_addr, REG_TIMER2);
  assign ctrl_wr = wr && is_bank0_reg(wr_addr, REG_TIMER_CTRL);

  // Flag set is applied after clear so an overflow coinciding with RST is never lost
  always_comb begin
    t1_reload_d = t1_reload_q;
    t2_reload_d = t2_reload_q;
    mt1_d       = mt1_q;
    mt2_d       = mt2_q;
    st1_d       = st1_q;
    st2_d       = st2_q;
    ft1_d       = ft1_q;
    ft2_d       = ft2_q;
    if (t1_wr) t1_reload_d = wr_data;
    if (t2_wr) t2_reload_d = wr_data;
    if (ctrl_wr) begin
      if (wr_data[CTRL_RST_BIT]) begin
        ft1_d = 1'b0;
        ft2_d = 1'b0;
      end else begin
        mt1_d = wr_data[CTRL_MT1_BIT];
        mt2_d = wr_data[CTRL_MT2_BIT];
        st2_d = wr_data[CTRL_ST2_BIT];
        st1_d = wr_data[CTRL_ST1_BIT];
      end
    end
    if (ovf1 && !mt1_q) ft1_d = 1'b1;
    if (ovf2 && !mt2_q) ft2_d = 1'b1;
    irq_d = ft1_d | ft2_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      t1_reload_q <= '0;
      t2_reload_q <= '0;
      mt1_q       <= 1'b0;
      mt2_q       <= 1'b0;
      st1_q       <= 1'b0;
      st2_q       <= 1'b0;
      ft1_q       <= 1'b0;
      ft2_q       <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      t1_reload_q <= t1_reload_d;
      t2_reload_q <= t2_reload_d;
      mt1_q       <= mt1_d;
      mt2_q       <= mt2_d;
      st1_q       <= st1_d;
      st2_q       <= st2_d;
      ft1_q       <= ft1_d;
      ft2_q       <= ft2_d;
      irq_q       <= irq_d;
    end
  end

  opl3_timer_chan #(.TICK_CYCLES(T1_TICK_CYCLES)) u_t1 (
    .clk    (clk),
    .reset  (reset),
    .start  (st1_d),
    .reload (t1_reload_q),
    .ovf    (ovf1)
  );

  opl3_timer_chan #(.TICK_CYCLES(T2_TICK_CYCLES)) u_t2 (
    .clk    (clk),
    .reset  (reset),
    .start  (st2_d),
    .reload (t2_reload_q),
    .ovf    (ovf2)
  );

  assign status     = status_t'{irq: irq_q, ft1: ft1_q, ft2: ft2_q, rsvd: 5'b0};
  assign irq        = irq_q;
  assign t1_running = st1_q;
  assign t2_running = st2_q;

endmodule

// File: tb/tb_opl3_timer_ctrl.sv
// Scoreboard bench for opl3_timer_ctrl with short ticks (T1=4, T2=16 clk).
module tb_opl3_timer_ctrl;
  import opl3_pkg::*;

  logic                  clk;
  logic                  reset;
  logic                  wr;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [7:0]            wr_data;
  logic [7:0]            status;
  logic                  irq;
  logic                  t1_running;
  logic                  t2_running;

  typedef struct {
    int unsigned cyc;
    string       tag;
    logic [7:0]  status;
    logic [1:0]  run;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned cyc      = 0;
  int unsigned n_ovf1   = 0;
  int unsigned n_ovf2   = 0;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  opl3_timer_ctrl #(.T1_TICK_CYCLES(4), .T2_TICK_CYCLES(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr         (wr),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .status     (status),
    .irq        (irq),
    .t1_running (t1_running),
    .t2_running (t2_running)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edge count plus internal overflow pulse counts
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (dut.ovf1) n_ovf1 <= n_ovf1 + 1;
    if (dut.ovf2) n_ovf2 <= n_ovf2 + 1;
  end

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp_v);
    n_checks++;
    if (obs != exp_v) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  task automatic push(input string tag, input int unsigned c, input logic [7:0] st,
                      input logic [1:0] run);
    sb_q.push_back('{cyc: c, tag: tag, status: st, run: run});
  endtask

  task automatic service();
    exp_t e;
    while (sb_q.size() != 0 && sb_q[0].cyc <= cyc) begin
      e = sb_q.pop_front();
      check({e.tag, "_cyc"}, cyc, e.cyc);
      check(e.tag, 32'(status), 32'(e.status));
      check({e.tag, "_irq"}, 32'(irq), 32'(e.status[7]));
      check({e.tag, "_run"}, 32'({t2_running, t1_running}), 32'(e.run));
    end
  endtask

  task automatic tick();
    @(negedge clk);
    service();
  endtask

  task automatic wait_until(input int unsigned c);
    while (cyc < c) tick();
  endtask

  task automatic drain(input int unsigned budget);
    int unsigned n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    if (sb_q.size() != 0) begin
      check("drain_timeout", 32'(sb_q.size()), 0);
      sb_q.delete();
    end
  endtask

  // Returns the cycle index of the edge that sampled the write
  task automatic do_write(input logic [ADDR_WIDTH-1:0] a, input logic [7:0] d,
                          output int unsigned w);
    wr      = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr      = 1'b0;
    w       = cyc;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    int unsigned t0, t1, w, o1, o2, c;
    reset   = 1'b1;
    wr      = 1'b0;
    wr_addr = '0;
    wr_data = '0;

    // 1: reset and idle, then writes to undecoded/bank-1 addresses
    do_reset();
    t0 = cyc; o1 = n_ovf1; o2 = n_ovf2;
    push("idle_a", t0 + 1, 8'h00, 2'b00);
    push("idle_b", t0 + 500, 8'h00, 2'b00);
    push("idle_c", t0 + 1000, 8'h00, 2'b00);
    drain(1100);
    check("idle_ovf1", n_ovf1 - o1, 0);
    check("idle_ovf2", n_ovf2 - o2, 0);
    do_write(9'h104, 8'h03, w);
    do_write(9'h005, 8'h03, w);
    do_write(9'h0FF, 8'h03, w);
    push("undecoded", w + 50, 8'h00, 2'b00);
    drain(100);

    // 2: T1 reload 0xFE, bank-1 alias of 0x02 must not disturb reload
    do_reset();
    do_write(9'h002, 8'hFE, w);
    do_write(9'h102, 8'h00, w);
    do_write(9'h004, 8'h01, t0);
    o1 = n_ovf1;
    push("t1_pre", t0 + 8, 8'h00, 2'b01);
    push("t1_first", t0 + 9, 8'hC0, 2'b01);
    push("t1_sticky", t0 + 30, 8'hC0, 2'b01);
    drain(100);
    wait_until(t0 + 44);
    check("t1_ovf_count", n_ovf1 - o1, 5);

    // 3: T2 reload 0xF0, RST clears flag while T2 keeps its phase
    do_reset();
    do_write(9'h003, 8'hF0, w);
    do_write(9'h004, 8'h02, t0);
    push("t2_pre", t0 + 256, 8'h00, 2'b10);
    push("t2_first", t0 + 257, 8'hA0, 2'b10);
    drain(400);
    wait_until(t0 + 300);
    do_write(9'h004, 8'h80, w);
    push("t2_rst", w, 8'h00, 2'b10);
    service();
    push("t2_second_pre", t0 + 512, 8'h00, 2'b10);
    push("t2_second", t0 + 513, 8'hA0, 2'b10);
    drain(400);

    // 4: T1 masked, overflows occur but no flag
    do_reset();
    do_write(9'h002, 8'hFE, w);
    do_write(9'h004, 8'h41, t0);
    o1 = n_ovf1;
    push("mask_a", t0 + 9, 8'h00, 2'b01);
    push("mask_b", t0 + 40, 8'h00, 2'b01);
    drain(100);
    wait_until(t0 + 44);
    check("mask_ovf_count", n_ovf1 - o1, 5);

    // 5: RST on the overflow cycle loses nothing; RST with other bits set leaves ST/MT alone
    do_reset();
    do_write(9'h002, 8'hFE, w);
    do_write(9'h004, 8'h01, t0);
    wait_until(t0 + 8);
    do_write(9'h004, 8'h80, w);
    push("rst_ovf_first", w, 8'hC0, 2'b01);
    service();
    wait_until(t0 + 20);
    do_write(9'h004, 8'hFF, w);
    push("rst_ff", w, 8'h00, 2'b01);
    service();
    push("rst_ff_reflag", t0 + 25, 8'hC0, 2'b01);
    drain(100);
    wait_until(t0 + 32);
    do_write(9'h004, 8'h80, w);
    push("rst_ovf_held", w, 8'hC0, 2'b01);
    service();

    // 6: stop at count 0x80, hold, restart reloads 0x00
    do_reset();
    do_write(9'h002, 8'h00, w);
    do_write(9'h004, 8'h01, t0);
    wait_until(t0 + 513);
    do_write(9'h004, 8'h00, w);
    push("hold_stop", w, 8'h00, 2'b00);
    service();
    o1 = n_ovf1;
    wait_until(w + 500);
    check("hold_count", 32'(dut.u_t1.cnt_q), 32'h80);
    check("hold_ovf", n_ovf1 - o1, 0);
    do_write(9'h004, 8'h01, t1);
    push("restart_pre", t1 + 1024, 8'h00, 2'b01);
    push("restart_ovf", t1 + 1025, 8'hC0, 2'b01);
    drain(1100);

    // 7: reset pin mid-count with FT1 set
    do_reset();
    do_write(9'h002, 8'hFE, w);
    do_write(9'h004, 8'h01, t0);
    push("mid_flag", t0 + 9, 8'hC0, 2'b01);
    wait_until(t0 + 12);
    o1 = n_ovf1;
    reset = 1'b1;
    tick();
    push("mid_reset", cyc, 8'h00, 2'b00);
    service();
    reset = 1'b0;
    c = cyc;
    push("mid_after", c + 100, 8'h00, 2'b00);
    drain(200);
    check("mid_ovf", n_ovf1 - o1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
